// File: rtl/risc_mem_pkg.sv
// Shared types and address map for the CPU/debug memory port arbiter.
package risc_mem_pkg;
  localparam int ADDR_W = 9;
  localparam int DATA_W = 16;
  localparam int RAM_AW = 8;
  localparam int IO_W   = 8;

  localparam logic [ADDR_W-1:0] LED_ADDR_DEF = 9'h100;
  localparam logic [ADDR_W-1:0] SW_ADDR_DEF  = 9'h140;

  typedef enum logic [1:0] {MNONE = 2'd0, MREAD = 2'd1, MWRITE = 2'd2} mem_cmd_e;
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, COMPLETE = 2'd2} arb_state_e;
  typedef enum logic {OWN_CPU = 1'b0, OWN_DBG = 1'b1} owner_e;

  typedef struct packed {
    mem_cmd_e          cmd;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// Arbiter (slave) to environment (master) bundle: both requester ports, the RAM pins and the LED/SW pins.
interface mem_port_arbiter_if;
  import risc_mem_pkg::*;

  logic              cpu_req;
  mem_cmd_e          cpu_cmd;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;

  logic              dbg_req;
  mem_cmd_e          dbg_cmd;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_ack;
  logic [DATA_W-1:0] dbg_rdata;

  logic [RAM_AW-1:0] mem_addr;
  logic              mem_write;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic [IO_W-1:0]   sw_in;
  logic [IO_W-1:0]   led_out;
  logic              bad_addr;

  modport slave (
    input  cpu_req, cpu_cmd, cpu_addr, cpu_wdata,
    input  dbg_req, dbg_cmd, dbg_addr, dbg_wdata,
    input  mem_rdata, sw_in,
    output cpu_ack, cpu_rdata, dbg_ack, dbg_rdata,
    output mem_addr, mem_write, mem_wdata, led_out, bad_addr
  );

  modport master (
    output cpu_req, cpu_cmd, cpu_addr, cpu_wdata,
    output dbg_req, dbg_cmd, dbg_addr, dbg_wdata,
    output mem_rdata, sw_in,
    input  cpu_ack, cpu_rdata, dbg_ack, dbg_rdata,
    input  mem_addr, mem_write, mem_wdata, led_out, bad_addr
  );
endinterface

// File: rtl/mem_io_decode.sv
// Combinational address/command classifier: RAM space, LED write, switch read or unmapped I/O.
module mem_io_decode
  import risc_mem_pkg::*;
#(
  parameter logic [ADDR_W-1:0] LED_ADDR = LED_ADDR_DEF,
  parameter logic [ADDR_W-1:0] SW_ADDR  = SW_ADDR_DEF
) (
  input  logic [ADDR_W-1:0] addr_i,
  input  mem_cmd_e          cmd_i,
  output logic              is_ram_o,
  output logic              is_led_wr_o,
  output logic              is_sw_rd_o,
  output logic              is_bad_o
);
  always_comb begin
    is_ram_o    = ~addr_i[ADDR_W-1];
    is_led_wr_o = (addr_i == LED_ADDR) && (cmd_i == MWRITE);
    is_sw_rd_o  = (addr_i == SW_ADDR) && (cmd_i == MREAD);
    // LED reads, switch writes and every other I/O address fall through to here.
    is_bad_o    = addr_i[ADDR_W-1] && !is_led_wr_o && !is_sw_rd_o;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// CPU/debug arbiter for the 256x16 RAM and LED/SW I/O; 3 cycles per access, unpipelined, loser's req waits.
// MEM_ARB_ROUND_ROBIN_EN selects round-robin on ties; otherwise the CPU always wins.
module mem_port_arbiter
  import risc_mem_pkg::*;
#(
  parameter logic [ADDR_W-1:0] LED_ADDR = LED_ADDR_DEF,
  parameter logic [ADDR_W-1:0] SW_ADDR  = SW_ADDR_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  mem_port_arbiter_if.slave bus
);
  arb_state_e        state_q;
  owner_e            own_q;
  logic [RAM_AW-1:0] mem_addr_q;
  logic              mem_write_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [IO_W-1:0]   led_q;
  logic              cpu_ack_q;
  logic              dbg_ack_q;
  logic              bad_q;
  logic              ram_rd_q;
  logic              sw_rd_q;
  logic              led_wr_q;
  logic              bad_pend_q;

  logic              cpu_win;
  req_t              grant_req;
  logic              is_ram;
  logic              is_led_wr;
  logic              is_sw_rd;
  logic              is_bad;
  logic [DATA_W-1:0] rdata_sel;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  owner_e last_q;
  // On a tie, whoever was not granted last goes first.
  assign cpu_win = bus.cpu_req && (!bus.dbg_req || (last_q == OWN_DBG));
`else
  assign cpu_win = bus.cpu_req;
`endif

  always_comb begin
    grant_req = '{cmd: bus.dbg_cmd, addr: bus.dbg_addr, wdata: bus.dbg_wdata};
    if (cpu_win) begin
      grant_req = '{cmd: bus.cpu_cmd, addr: bus.cpu_addr, wdata: bus.cpu_wdata};
    end
  end

  mem_io_decode #(
    .LED_ADDR (LED_ADDR),
    .SW_ADDR  (SW_ADDR)
  ) u_decode (
    .addr_i      (grant_req.addr),
    .cmd_i       (grant_req.cmd),
    .is_ram_o    (is_ram),
    .is_led_wr_o (is_led_wr),
    .is_sw_rd_o  (is_sw_rd),
    .is_bad_o    (is_bad)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      own_q       <= OWN_CPU;
      mem_addr_q  <= '0;
      mem_write_q <= 1'b0;
      mem_wdata_q <= '0;
      led_q       <= '0;
      cpu_ack_q   <= 1'b0;
      dbg_ack_q   <= 1'b0;
      bad_q       <= 1'b0;
      ram_rd_q    <= 1'b0;
      sw_rd_q     <= 1'b0;
      led_wr_q    <= 1'b0;
      bad_pend_q  <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_q      <= OWN_DBG;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.cpu_req || bus.dbg_req) begin
            state_q     <= ACCESS;
            own_q       <= cpu_win ? OWN_CPU : OWN_DBG;
            mem_addr_q  <= grant_req.addr[RAM_AW-1:0];
            mem_write_q <= is_ram && (grant_req.cmd == MWRITE);
            mem_wdata_q <= grant_req.wdata;
            ram_rd_q    <= is_ram && (grant_req.cmd == MREAD);
            sw_rd_q     <= is_sw_rd;
            led_wr_q    <= is_led_wr;
            bad_pend_q  <= is_bad;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_q      <= cpu_win ? OWN_CPU : OWN_DBG;
`endif
          end
        end
        ACCESS: begin
          state_q     <= COMPLETE;
          mem_write_q <= 1'b0;
          if (led_wr_q) begin
            led_q <= mem_wdata_q[IO_W-1:0];
          end
          cpu_ack_q <= (own_q == OWN_CPU);
          dbg_ack_q <= (own_q == OWN_DBG);
          bad_q     <= bad_pend_q;
        end
        COMPLETE: begin
          state_q   <= IDLE;
          cpu_ack_q <= 1'b0;
          dbg_ack_q <= 1'b0;
          bad_q     <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // RAM dout is only valid in COMPLETE, which is exactly when an ack is up.
  always_comb begin
    rdata_sel = '0;
    if (ram_rd_q) begin
      rdata_sel = bus.mem_rdata;
    end else if (sw_rd_q) begin
      rdata_sel = {{(DATA_W-IO_W){1'b0}}, bus.sw_in};
    end
  end

  assign bus.cpu_ack   = cpu_ack_q;
  assign bus.dbg_ack   = dbg_ack_q;
  assign bus.cpu_rdata = cpu_ack_q ? rdata_sel : '0;
  assign bus.dbg_rdata = dbg_ack_q ? rdata_sel : '0;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_write = mem_write_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.led_out   = led_q;
  assign bus.bad_addr  = bad_q;
endmodule
